// File: rtl/turf_event_fragmenter.sv
// turf_event_fragmenter
// Takes the assembled event qword stream and sends it out as UDP fragments. One fragment
// is buffered at a time: fill the buffer, emit the UDP header, then the fragment header
// and buffered payload, then wait the configured holdoff before the next fragment.
// Closed destinations consume and discard the whole event.
// Optional build macro: FRAGMENTER_STATS_EN builds the saturating drop counter
// (otherwise drop_count_o is tied to zero).

module turf_event_fragmenter #(
    parameter int BUF_DEPTH = 1024,
    parameter int HOLDOFF_W = 32
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [63:0] s_evdata_tdata,
    input  logic        s_evdata_tvalid,
    output logic        s_evdata_tready,
    input  logic        s_evdata_tlast,
    output logic [63:0] m_udphdr_tdata,
    output logic        m_udphdr_tvalid,
    input  logic        m_udphdr_tready,
    output logic [63:0] m_udpdata_tdata,
    output logic [7:0]  m_udpdata_tkeep,
    output logic        m_udpdata_tlast,
    output logic        m_udpdata_tvalid,
    input  logic        m_udpdata_tready,
    input  logic [9:0]  nfragment_count_i,
    input  logic [31:0] fragment_holdoff_i,
    input  logic [31:0] event_ip_i,
    input  logic [15:0] event_port_i,
    input  logic        event_open_i,
    output logic [31:0] event_count_o,
    output logic [15:0] drop_count_o
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, FILL, HDR, PAYLOAD, HOLDOFF, DROP} state_t;

    state_t               state;
    state_t               state_next;

    logic [31:0]          lat_ip;
    logic [15:0]          lat_port;
    logic [9:0]           lat_nfrag;
    logic [HOLDOFF_W-1:0] lat_holdoff;
    logic [HOLDOFF_W-1:0] hold_cnt;
    logic [15:0]          frag_idx;
    logic [CW-1:0]        nbeats;
    logic [CW-1:0]        pay_cnt;
    logic                 last_frag;
    logic [31:0]          event_count;
    logic [63:0]          out_data;
    logic [63:0]          rd_data;
    logic [AW-1:0]        rd_addr;
    logic [63:0]          buf_mem [BUF_DEPTH];

    logic                 in_accept;
    logic                 hdr_fire;
    logic                 pay_fire;
    logic                 pay_final;
    logic                 fill_end;
    logic                 frag_done;
    logic [15:0]          udp_len;

    assign in_accept = s_evdata_tvalid & s_evdata_tready;
    assign hdr_fire  = m_udphdr_tvalid & m_udphdr_tready;
    assign pay_fire  = m_udpdata_tvalid & m_udpdata_tready;
    assign pay_final = pay_fire & m_udpdata_tlast;
    assign fill_end  = (state == FILL) & in_accept & (s_evdata_tlast | (nbeats == CW'(lat_nfrag)));
    assign frag_done = (pay_final & (lat_holdoff == '0)) | ((state == HOLDOFF) & (hold_cnt == '0));
    assign udp_len   = 16'd16 + (16'(nbeats) << 3);
    // Read address runs one beat ahead so rd_data already holds the next payload qword
    assign rd_addr   = pay_fire ? (pay_cnt[AW-1:0] + AW'(1)) : pay_cnt[AW-1:0];
    assign event_count_o = event_count;

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (s_evdata_tvalid) state_next = event_open_i ? FILL : DROP;
            FILL:    if (fill_end) state_next = HDR;
            HDR:     if (hdr_fire) state_next = PAYLOAD;
            PAYLOAD: begin
                if (pay_final) begin
                    if (lat_holdoff != '0) state_next = HOLDOFF;
                    else                   state_next = last_frag ? IDLE : FILL;
                end
            end
            HOLDOFF: if (hold_cnt == '0) state_next = last_frag ? IDLE : FILL;
            DROP:    if (in_accept && s_evdata_tlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and data outputs decoded from the current state
    always_comb begin
        s_evdata_tready  = (state == FILL) || (state == DROP);
        m_udphdr_tvalid  = (state == HDR);
        m_udphdr_tdata   = {lat_ip, lat_port, udp_len};
        m_udpdata_tvalid = (state == PAYLOAD);
        m_udpdata_tdata  = out_data;
        m_udpdata_tkeep  = 8'hFF;
        m_udpdata_tlast  = (state == PAYLOAD) && (pay_cnt == nbeats);
    end

    // Fragment buffer: written while filling, read synchronously one beat ahead while sending
    always_ff @(posedge aclk) begin
        if ((state == FILL) && in_accept) buf_mem[nbeats[AW-1:0]] <= s_evdata_tdata;
        rd_data <= buf_mem[rd_addr];
    end

    // Per-event configuration, fragment bookkeeping and event counter
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lat_ip      <= '0;
            lat_port    <= '0;
            lat_nfrag   <= '0;
            lat_holdoff <= '0;
            hold_cnt    <= '0;
            frag_idx    <= '0;
            nbeats      <= '0;
            pay_cnt     <= '0;
            last_frag   <= 1'b0;
            event_count <= '0;
            out_data    <= '0;
        end else begin
            if ((state == IDLE) && s_evdata_tvalid && event_open_i) begin
                lat_ip      <= event_ip_i;
                lat_port    <= event_port_i;
                lat_nfrag   <= nfragment_count_i;
                lat_holdoff <= HOLDOFF_W'(fragment_holdoff_i);
                frag_idx    <= '0;
                nbeats      <= '0;
            end
            if ((state == FILL) && in_accept) nbeats <= nbeats + CW'(1);
            if (fill_end) begin
                last_frag <= s_evdata_tlast;
                pay_cnt   <= '0;
            end
            if (hdr_fire) begin
                out_data <= {event_count, frag_idx, 15'd0, last_frag};
                pay_cnt  <= '0;
            end
            if (pay_fire) begin
                out_data <= rd_data;
                pay_cnt  <= pay_cnt + CW'(1);
            end
            if (pay_final) hold_cnt <= lat_holdoff - HOLDOFF_W'(1);
            if ((state == HOLDOFF) && (hold_cnt != '0)) hold_cnt <= hold_cnt - HOLDOFF_W'(1);
            if (frag_done) begin
                if (last_frag) begin
                    event_count <= event_count + 32'd1;
                end else begin
                    frag_idx <= frag_idx + 16'd1;
                    nbeats   <= '0;
                end
            end
        end
    end

`ifdef FRAGMENTER_STATS_EN
    logic [15:0] drop_count;

    // Saturating count of events discarded because the destination was closed
    always_ff @(posedge aclk) begin
        if (!aresetn)
            drop_count <= '0;
        else if ((state == DROP) && in_accept && s_evdata_tlast && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
    end

    assign drop_count_o = drop_count;
`else
    assign drop_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_turf_event_fragmenter.sv
// tb_turf_event_fragmenter
// Directed bench: drives events, collects UDP headers and payload beats on the falling
// edge, and compares them against expected fragments and hand-computed constants.

module tb_turf_event_fragmenter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [63:0] s_evdata_tdata;
    logic        s_evdata_tvalid;
    logic        s_evdata_tready;
    logic        s_evdata_tlast;
    logic [63:0] m_udphdr_tdata;
    logic        m_udphdr_tvalid;
    logic        m_udphdr_tready;
    logic [63:0] m_udpdata_tdata;
    logic [7:0]  m_udpdata_tkeep;
    logic        m_udpdata_tlast;
    logic        m_udpdata_tvalid;
    logic        m_udpdata_tready;
    logic [9:0]  nfragment_count_i;
    logic [31:0] fragment_holdoff_i;
    logic [31:0] event_ip_i;
    logic [15:0] event_port_i;
    logic        event_open_i;
    logic [31:0] event_count_o;
    logic [15:0] drop_count_o;

    always #5 aclk = ~aclk;

    turf_event_fragmenter #(.BUF_DEPTH(1024), .HOLDOFF_W(32)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_evdata_tdata     (s_evdata_tdata),
        .s_evdata_tvalid    (s_evdata_tvalid),
        .s_evdata_tready    (s_evdata_tready),
        .s_evdata_tlast     (s_evdata_tlast),
        .m_udphdr_tdata     (m_udphdr_tdata),
        .m_udphdr_tvalid    (m_udphdr_tvalid),
        .m_udphdr_tready    (m_udphdr_tready),
        .m_udpdata_tdata    (m_udpdata_tdata),
        .m_udpdata_tkeep    (m_udpdata_tkeep),
        .m_udpdata_tlast    (m_udpdata_tlast),
        .m_udpdata_tvalid   (m_udpdata_tvalid),
        .m_udpdata_tready   (m_udpdata_tready),
        .nfragment_count_i  (nfragment_count_i),
        .fragment_holdoff_i (fragment_holdoff_i),
        .event_ip_i         (event_ip_i),
        .event_port_i       (event_port_i),
        .event_open_i       (event_open_i),
        .event_count_o      (event_count_o),
        .drop_count_o       (drop_count_o)
    );

    int assertCount = 0;
    int failCount   = 0;

    logic [64:0] srcQ [$];
    logic [63:0] hdrQ [$];
    logic [64:0] datQ [$];
    int          lastTicks [$];
    int          hdrTicks [$];
    int          tickNum = 0;
    bit          rngMode = 1'b0;
    bit          datStall = 1'b0;
    bit          hdrStall = 1'b0;
    logic [64:0] datStallBeat;
    logic [63:0] hdrStallWord;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] hdrAt(input int i);
        return (i < hdrQ.size()) ? hdrQ[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [64:0] datAt(input int i);
        return (i < datQ.size()) ? datQ[i] : {1'b1, 64'hDEAD_DEAD_DEAD_DEAD};
    endfunction

    // One clock of bench activity on the falling edge: drive source, sinks, record handshakes
    task automatic tick();
        @(negedge aclk);
        tickNum++;
        if (datStall) begin
            checkOutput("udata_hold_valid", 64'(m_udpdata_tvalid), 64'd1);
            checkOutput("udata_hold_beat", {m_udpdata_tdata[62:0], m_udpdata_tlast}, {datStallBeat[62:0], datStallBeat[64]});
        end
        if (hdrStall) begin
            checkOutput("uhdr_hold_valid", 64'(m_udphdr_tvalid), 64'd1);
            checkOutput("uhdr_hold_data", m_udphdr_tdata, hdrStallWord);
        end
        if (srcQ.size() > 0 && (!rngMode || $urandom_range(0, 3) != 0)) begin
            s_evdata_tvalid = 1'b1;
            {s_evdata_tlast, s_evdata_tdata} = srcQ[0];
            if (s_evdata_tready) void'(srcQ.pop_front());
        end else begin
            s_evdata_tvalid = 1'b0;
            s_evdata_tlast  = 1'b0;
            s_evdata_tdata  = '0;
        end
        m_udphdr_tready  = rngMode ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_udpdata_tready = rngMode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (m_udphdr_tvalid && m_udphdr_tready) begin
            hdrQ.push_back(m_udphdr_tdata);
            hdrTicks.push_back(tickNum);
        end
        if (m_udpdata_tvalid && m_udpdata_tready) begin
            datQ.push_back({m_udpdata_tlast, m_udpdata_tdata});
            if (m_udpdata_tlast) lastTicks.push_back(tickNum);
        end
        hdrStall     = m_udphdr_tvalid && !m_udphdr_tready;
        hdrStallWord = m_udphdr_tdata;
        datStall     = m_udpdata_tvalid && !m_udpdata_tready;
        datStallBeat = {m_udpdata_tlast, m_udpdata_tdata};
    endtask

    // Push one event into the source and run until everything has drained
    task automatic applyStimulus(input string tag, input int n, input logic [31:0] ip, input logic [15:0] port,
                                 input int nfrag, input int holdoff, input bit open, input logic [31:0] dtag,
                                 input int budget);
        int quiet;
        int cyc;
        event_ip_i         = ip;
        event_port_i       = port;
        nfragment_count_i  = 10'(nfrag);
        fragment_holdoff_i = 32'(holdoff);
        event_open_i       = open;
        hdrQ.delete();
        datQ.delete();
        lastTicks.delete();
        hdrTicks.delete();
        for (int i = 0; i < n; i++) srcQ.push_back({(i == n - 1), dtag, 32'(i)});
        quiet = 0;
        cyc   = 0;
        while (quiet < 30 && cyc < budget) begin
            tick();
            cyc++;
            if (srcQ.size() == 0 && !m_udphdr_tvalid && !m_udpdata_tvalid) quiet++;
            else quiet = 0;
        end
        checkOutput({tag, "_drained"}, 64'(quiet >= 30), 64'd1);
    endtask

    // Compare collected fragments against the expected split of the event
    task automatic checkEvent(input string tag, input int n, input logic [31:0] ip, input logic [15:0] port,
                              input int nfrag, input logic [31:0] evCount, input logic [31:0] dtag);
        int          expFrags;
        int          pos;
        int          p;
        int          cnt;
        bit          last;
        logic [64:0] b;
        expFrags = (n + nfrag) / (nfrag + 1);
        checkOutput({tag, "_nhdr"}, 64'(hdrQ.size()), 64'(expFrags));
        checkOutput({tag, "_nbeat"}, 64'(datQ.size()), 64'(n + expFrags));
        if (hdrQ.size() == expFrags && datQ.size() == n + expFrags) begin
            pos = 0;
            p   = 0;
            for (int f = 0; f < expFrags; f++) begin
                cnt  = (n - pos < nfrag + 1) ? (n - pos) : (nfrag + 1);
                last = (pos + cnt == n);
                checkOutput($sformatf("%s_hdr%0d", tag, f), hdrQ[f], {ip, port, 16'(16 + 8 * cnt)});
                b = datQ[p];
                checkOutput($sformatf("%s_fh%0d", tag, f), b[63:0], {evCount, 16'(f), 15'd0, last});
                checkOutput($sformatf("%s_fhlast%0d", tag, f), 64'(b[64]), 64'd0);
                p++;
                for (int k = 0; k < cnt; k++) begin
                    b = datQ[p];
                    checkOutput($sformatf("%s_d%0d_%0d", tag, f, k), b[63:0], {dtag, 32'(pos + k)});
                    checkOutput($sformatf("%s_l%0d_%0d", tag, f, k), 64'(b[64]), 64'(k == cnt - 1));
                    p++;
                end
                pos += cnt;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        logic [64:0] b;
        aresetn            = 1'b0;
        s_evdata_tdata     = '0;
        s_evdata_tvalid    = 1'b0;
        s_evdata_tlast     = 1'b0;
        m_udphdr_tready    = 1'b0;
        m_udpdata_tready   = 1'b0;
        nfragment_count_i  = '0;
        fragment_holdoff_i = '0;
        event_ip_i         = '0;
        event_port_i       = '0;
        event_open_i       = 1'b0;
        repeat (3) tick();
        checkOutput("rst_tready", 64'(s_evdata_tready), 64'd0);
        checkOutput("rst_hvalid", 64'(m_udphdr_tvalid), 64'd0);
        checkOutput("rst_dvalid", 64'(m_udpdata_tvalid), 64'd0);
        checkOutput("rst_evcnt", 64'(event_count_o), 64'd0);
        checkOutput("rst_dropcnt", 64'(drop_count_o), 64'd0);
        aresetn = 1'b1;
        tick();

        $display("[TB] test 1: 10-qword event, nfrag=3");
        applyStimulus("t1", 10, 32'h0A000001, 16'h5678, 3, 0, 1'b1, 32'hA1A1_0001, 500);
        checkEvent("t1", 10, 32'h0A000001, 16'h5678, 3, 32'd0, 32'hA1A1_0001);
        checkOutput("t1_hdr0_const", hdrAt(0), 64'h0A000001_5678_0030);
        checkOutput("t1_hdr1_const", hdrAt(1), 64'h0A000001_5678_0030);
        checkOutput("t1_hdr2_const", hdrAt(2), 64'h0A000001_5678_0020);
        b = datAt(0);
        checkOutput("t1_fh0_const", b[63:0], 64'h0000_0000_0000_0000);
        b = datAt(5);
        checkOutput("t1_fh1_const", b[63:0], 64'h0000_0000_0001_0000);
        b = datAt(10);
        checkOutput("t1_fh2_const", b[63:0], 64'h0000_0000_0002_0001);
        b = datAt(11);
        checkOutput("t1_d8_const", b[63:0], 64'hA1A1_0001_0000_0008);
        checkOutput("t1_tkeep", 64'(m_udpdata_tkeep), 64'hFF);
        checkOutput("t1_evcnt", 64'(event_count_o), 64'd1);

        $display("[TB] test 2: single-qword event");
        applyStimulus("t2", 1, 32'h0A000001, 16'h5678, 3, 0, 1'b1, 32'hB2B2_0002, 200);
        checkEvent("t2", 1, 32'h0A000001, 16'h5678, 3, 32'd1, 32'hB2B2_0002);
        checkOutput("t2_hdr_const", hdrAt(0), 64'h0A000001_5678_0018);
        b = datAt(0);
        checkOutput("t2_fh_const", b[63:0], 64'h0000_0001_0000_0001);
        checkOutput("t2_evcnt", 64'(event_count_o), 64'd2);

        $display("[TB] test 3: closed port drops event");
        applyStimulus("t3", 5, 32'h0A000002, 16'h1111, 3, 0, 1'b0, 32'hC3C3_0003, 200);
        checkOutput("t3_nhdr", 64'(hdrQ.size()), 64'd0);
        checkOutput("t3_nbeat", 64'(datQ.size()), 64'd0);
        checkOutput("t3_consumed", 64'(srcQ.size()), 64'd0);
`ifdef FRAGMENTER_STATS_EN
        checkOutput("t3_dropcnt", 64'(drop_count_o), 64'd1);
`else
        checkOutput("t3_dropcnt", 64'(drop_count_o), 64'd0);
`endif
        checkOutput("t3_evcnt", 64'(event_count_o), 64'd2);

        $display("[TB] test 4: holdoff of 20 clocks");
        applyStimulus("t4", 8, 32'h0A000001, 16'h5678, 3, 20, 1'b1, 32'hD4D4_0004, 500);
        checkEvent("t4", 8, 32'h0A000001, 16'h5678, 3, 32'd2, 32'hD4D4_0004);
        if (hdrTicks.size() >= 2 && lastTicks.size() >= 1)
            checkOutput("t4_holdoff_gap", 64'((hdrTicks[1] - lastTicks[0] - 1) >= 20), 64'd1);
        else
            checkOutput("t4_holdoff_frags", 64'(hdrTicks.size()), 64'd2);
        checkOutput("t4_evcnt", 64'(event_count_o), 64'd3);

        $display("[TB] test 5: 4096-qword event with random backpressure");
        rngMode = 1'b1;
        applyStimulus("t5", 4096, 32'hC0A8_0101, 16'h9ABC, 1023, 0, 1'b1, 32'hE5E5_0005, 40000);
        rngMode = 1'b0;
        checkEvent("t5", 4096, 32'hC0A8_0101, 16'h9ABC, 1023, 32'd3, 32'hE5E5_0005);
        checkOutput("t5_hdr3_const", hdrAt(3), 64'hC0A8_0101_9ABC_2010);
        checkOutput("t5_evcnt", 64'(event_count_o), 64'd4);

        $display("[TB] test 6: reset during payload");
        event_ip_i         = 32'h0A000001;
        event_port_i       = 16'h5678;
        nfragment_count_i  = 10'd3;
        fragment_holdoff_i = '0;
        event_open_i       = 1'b1;
        for (int i = 0; i < 10; i++) srcQ.push_back({(i == 9), 32'hF6F6_0006, 32'(i)});
        cyc = 0;
        while (!m_udpdata_tvalid && cyc < 100) begin
            tick();
            cyc++;
        end
        checkOutput("t6_reached_payload", 64'(m_udpdata_tvalid), 64'd1);
        srcQ.delete();
        aresetn = 1'b0;
        tick();
        checkOutput("t6_dvalid", 64'(m_udpdata_tvalid), 64'd0);
        checkOutput("t6_hvalid", 64'(m_udphdr_tvalid), 64'd0);
        checkOutput("t6_tready", 64'(s_evdata_tready), 64'd0);
        checkOutput("t6_evcnt_rst", 64'(event_count_o), 64'd0);
        checkOutput("t6_dropcnt_rst", 64'(drop_count_o), 64'd0);
        aresetn = 1'b1;
        applyStimulus("t6", 2, 32'h0A000001, 16'h5678, 3, 0, 1'b1, 32'h7777_0007, 200);
        checkEvent("t6", 2, 32'h0A000001, 16'h5678, 3, 32'd0, 32'h7777_0007);
        b = datAt(0);
        checkOutput("t6_fh_const", b[63:0], 64'h0000_0000_0000_0001);
        checkOutput("t6_evcnt", 64'(event_count_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
